// File: rtl/register_file_mp.sv
// Multi-read-port scratch register file: one write port, NUM_RD_PORTS registered
// read ports with write-first bypass, and a hardware clear sweep after reset or on request.
module register_file_mp #(
  parameter int unsigned DATATYPE_SIZE = 8,
  parameter int unsigned ADDR_WIDTH    = 6,
  parameter int unsigned NUM_RD_PORTS  = 2
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic                                  wr_en,
  input  logic [ADDR_WIDTH-1:0]                 wr_addr,
  input  logic [DATATYPE_SIZE-1:0]              wr_data,
  input  logic [NUM_RD_PORTS-1:0]               rd_en,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]    rd_addr,
  output logic [NUM_RD_PORTS*DATATYPE_SIZE-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]               rd_valid,
  input  logic                                  clr,
  output logic                                  busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;

  localparam logic [ADDR_WIDTH:0] IdxOne  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] LastIdx = (ADDR_WIDTH + 1)'(DEPTH - 1);

  logic [0:0]                              state_q, state_d;
  logic [ADDR_WIDTH:0]                     clr_idx_q, clr_idx_d;
  logic [DATATYPE_SIZE-1:0]                mem_q [DEPTH];
  logic [NUM_RD_PORTS*DATATYPE_SIZE-1:0]   rd_data_q, rd_data_d;
  logic [NUM_RD_PORTS-1:0]                 rd_valid_q, rd_valid_d;
  logic                                    idle;
  logic                                    wr_fire;

  assign idle    = (state_q == StIdle);
  // A clear request in the same cycle wins over a write.
  assign wr_fire = idle & wr_en & ~clr;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      StIdle: begin
        if (clr) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end
      end
      StClear: begin
        clr_idx_d = clr_idx_q + IdxOne;
        if (clr_idx_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      if (idle && rd_en[p]) begin
        rd_valid_d[p] = 1'b1;
        if (wr_fire && (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr)) begin
          rd_data_d[p*DATATYPE_SIZE +: DATATYPE_SIZE] = wr_data;
        end else begin
          rd_data_d[p*DATATYPE_SIZE +: DATATYPE_SIZE] = mem_q[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end
    end
  end

  // Array has no reset; the sweep is what zeroes it.
  always_ff @(posedge CLK) begin
    if (!idle) begin
      mem_q[clr_idx_q[ADDR_WIDTH-1:0]] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StClear;
      clr_idx_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == StClear);

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: reference array plus per-port expected-data queues.
module tb_register_file_mp;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int NP    = 2;
  localparam int DEPTH = 64;

  logic             CLK     = 1'b0;
  logic             RST_N   = 1'b0;
  logic             wr_en   = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic [NP-1:0]    rd_en   = '0;
  logic [NP*AW-1:0] rd_addr = '0;
  logic             clr     = 1'b0;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0]    rd_valid;
  logic             busy;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] model     [DEPTH];
  logic [DW-1:0] last_data [NP];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  int            sweep_left;

  register_file_mp #(
    .DATATYPE_SIZE(DW),
    .ADDR_WIDTH   (AW),
    .NUM_RD_PORTS (NP)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .clr     (clr),
    .busy    (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sweep_left = DEPTH;
    exp_q0.delete();
    exp_q1.delete();
    for (int p = 0; p < NP; p++) last_data[p] = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic check_port(input int p);
    logic [DW-1:0] e;
    logic          has;
    has = (p == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
    if (has) begin
      e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("rd_valid[%0d] on read", p), {7'd0, rd_valid[p]}, 8'd1);
      check($sformatf("rd_data[%0d] on read", p), rd_data[p*DW +: DW], e);
      last_data[p] = e;
    end else begin
      check($sformatf("rd_valid[%0d] quiet", p), {7'd0, rd_valid[p]}, 8'd0);
      check($sformatf("rd_data[%0d] hold", p), rd_data[p*DW +: DW], last_data[p]);
    end
  endtask

  // One clock of stimulus; called #1 after an edge so inputs change away from it.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [NP-1:0] re, input logic [AW-1:0] ra0,
                      input logic [AW-1:0] ra1, input logic c);
    logic [AW-1:0] ra [NP];
    logic [DW-1:0] e;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = {ra1, ra0};
    clr     = c;
    ra[0]   = ra0;
    ra[1]   = ra1;
    if (sweep_left == 0) begin
      for (int p = 0; p < NP; p++) begin
        if (re[p]) begin
          e = (we && !c && (wa == ra[p])) ? wd : model[ra[p]];
          if (p == 0) exp_q0.push_back(e);
          else exp_q1.push_back(e);
        end
      end
    end
    @(posedge CLK);
    if (sweep_left > 0) begin
      sweep_left--;
    end else if (c) begin
      sweep_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (we) begin
      model[wa] = wd;
    end
    #1;
    check("busy", {7'd0, busy}, {7'd0, (sweep_left != 0)});
    for (int p = 0; p < NP; p++) check_port(p);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 2'b11, AW'(i), AW'(DEPTH - 1 - i), 1'b0);
    idle_cycles(1);
  endtask

  initial begin
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("reset busy", {7'd0, busy}, 8'd1);
    check("reset rd_valid", {6'd0, rd_valid}, 8'd0);
    check("reset rd_data0", rd_data[0 +: DW], 8'd0);
    check("reset rd_data1", rd_data[DW +: DW], 8'd0);
    RST_N = 1'b1;

    // Power-up sweep, then every entry reads zero.
    idle_cycles(DEPTH);
    read_all();

    // Write then dual-port read of the same address.
    step(1'b1, 6'd5, 8'hA5, 2'b00, '0, '0, 1'b0);
    step(1'b0, '0, '0, 2'b11, 6'd5, 6'd5, 1'b0);
    idle_cycles(1);

    // Write-first bypass on port 0, plain read on port 1.
    step(1'b1, 6'd9, 8'h11, 2'b00, '0, '0, 1'b0);
    step(1'b1, 6'd8, 8'h77, 2'b00, '0, '0, 1'b0);
    step(1'b1, 6'd9, 8'h3C, 2'b11, 6'd9, 6'd8, 1'b0);
    step(1'b0, '0, '0, 2'b01, 6'd9, '0, 1'b0);
    idle_cycles(1);

    // Fill, then clear with a colliding write; sweep ignores all requests.
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), DW'(i + 1), 2'b00, '0, '0, 1'b0);
    step(1'b1, 6'd2, 8'hFF, 2'b00, '0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 6'd2, 8'hEE, 2'b11, AW'(i), AW'(DEPTH - 1 - i), (i == 10));
    end
    read_all();

    // Reset in the middle of a clear sweep with non-zero held read data.
    step(1'b1, 6'd7, 8'h5A, 2'b00, '0, '0, 1'b0);
    step(1'b0, '0, '0, 2'b11, 6'd7, 6'd7, 1'b0);
    step(1'b0, '0, '0, 2'b00, '0, '0, 1'b1);
    idle_cycles(30);
    RST_N = 1'b0;
    #2;
    check("async rst rd_valid", {6'd0, rd_valid}, 8'd0);
    check("async rst rd_data0", rd_data[0 +: DW], 8'd0);
    check("async rst rd_data1", rd_data[DW +: DW], 8'd0);
    check("async rst busy", {7'd0, busy}, 8'd1);
    model_reset();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    idle_cycles(DEPTH);
    read_all();

    // Back-to-back reads on port 0 only.
    step(1'b1, 6'd0, 8'd10, 2'b00, '0, '0, 1'b0);
    step(1'b1, 6'd1, 8'd20, 2'b00, '0, '0, 1'b0);
    step(1'b1, 6'd2, 8'd30, 2'b00, '0, '0, 1'b0);
    step(1'b1, 6'd3, 8'd40, 2'b00, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 2'b01, AW'(i), '0, 1'b0);
    idle_cycles(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
